// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide, one bit per cycle, results held in hi/lo until the next completion.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       div_mult_ctrl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, FINISH, DZ} state_t;

  localparam logic [1:0]       CMD_MULT = 2'b01;
  localparam logic [1:0]       CMD_DIV  = 2'b10;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   acc;     // Booth accumulator / division remainder
  logic [WIDTH-1:0] mq;      // multiplier / quotient shift register
  logic [WIDTH-1:0] opnd;    // multiplicand / divisor magnitude
  logic             q_m1;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   opnd_ext, booth_sum, div_shift, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] quot_s, rem_s;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
    // The extra accumulator bit keeps Booth from overflowing on a -2^(WIDTH-1) multiplicand.
    opnd_ext  = is_div ? {1'b0, opnd} : {opnd[WIDTH-1], opnd};
    booth_sum = acc;
    case ({mq[0], q_m1})
      2'b01:   booth_sum = acc + opnd_ext;
      2'b10:   booth_sum = acc - opnd_ext;
      default: booth_sum = acc;
    endcase
    div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    div_ge    = (div_shift >= opnd_ext);
    div_rem   = div_ge ? (div_shift - opnd_ext) : div_shift;
    quot_s    = (sign_a ^ sign_b) ? -mq : mq;
    rem_s     = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      q_m1     <= 1'b0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && div_mult_ctrl == CMD_MULT) begin
            acc      <= '0;
            mq       <= b;
            opnd     <= a;
            q_m1     <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            count    <= '0;
            state    <= MULT_RUN;
          end else if (start && div_mult_ctrl == CMD_DIV) begin
            busy <= 1'b1;
            if (b != '0) begin
              acc      <= '0;
              mq       <= abs_a;
              opnd     <= abs_b;
              sign_a   <= a[WIDTH-1];
              sign_b   <= b[WIDTH-1];
              is_div   <= 1'b1;
              div_zero <= 1'b0;
              count    <= '0;
              state    <= DIV_RUN;
            end else begin
              state <= DZ;
            end
          end
        end
        MULT_RUN: begin
          acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq    <= {booth_sum[0], mq[WIDTH-1:1]};
          q_m1  <= mq[0];
          count <= count + 1'b1;
          if (count == LAST) state <= FINISH;
        end
        DIV_RUN: begin
          acc   <= div_rem;
          mq    <= {mq[WIDTH-2:0], div_ge};
          count <= count + 1'b1;
          if (count == LAST) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            hi <= rem_s;
            lo <= quot_s;
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= mq;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DZ: begin
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ctrl;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .div_mult_ctrl(ctrl), .start(start),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
  task automatic model(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (c == 2'b01) begin
      p = sx * sy;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dz = 1'b0;
    end else if (c == 2'b10) begin
      if (y == '0) begin
        exp_dz = 1'b1;
      end else begin
        q = sx / sy;
        r = sx % sy;
        exp_lo = q[31:0];
        exp_hi = r[31:0];
        exp_dz = 1'b0;
      end
    end
  endtask

  // Issue one command; b2b=1 means called at the done cycle of the previous op.
  // restart_at >= 0 pulses a second start that many cycles into the operation.
  task automatic op(input string tag, input logic [1:0] c, input logic [W-1:0] x,
                    input logic [W-1:0] y, input bit b2b, input int restart_at);
    int edges, busy_cnt, want;
    want = (c == 2'b10 && y == '0) ? 1 : W + 1;
    if (!b2b) begin
      @(negedge clk);
      check({tag, "_idle_done"}, 64'(done), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    end
    ctrl = c; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ctrl = 2'($urandom);
    a = $urandom;
    b = $urandom;
    model(c, x, y);
    edges = 0;
    busy_cnt = 0;
    while (edges < 100) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) break;
      if (edges == restart_at) begin
        start = 1'b1; ctrl = 2'b01; a = $urandom; b = $urandom;
      end
      @(posedge clk);
      edges++;
      #1 start = 1'b0;
    end
    check({tag, "_latency"}, 64'(edges), 64'(want));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(want));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic [W-1:0] corners [6];
    corners = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h8000_0001};

    reset = 1'b0; start = 1'b0; ctrl = 2'b00; a = '0; b = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_zero), 64'd0);
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Commands 00 and 11 are no-ops.
    ctrl = 2'b11; start = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clk);
    check("nop11_busy", 64'(busy), 64'd0);
    ctrl = 2'b00;
    @(negedge clk);
    check("nop00_busy", 64'(busy), 64'd0);
    start = 1'b0;

    op("m_7x-3", 2'b01, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
    op("m_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
    op("d_-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    op("d_100_7", 2'b10, 32'd100, 32'd7, 1'b0, -1);
    op("d_by0", 2'b10, 32'd5, 32'd0, 1'b0, -1);
    op("m_clr_dz", 2'b01, 32'd6, 32'hFFFF_FFFF, 1'b0, -1);
    op("d_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5);
    op("b2b_first", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, -1);
    op("b2b_second", 2'b10, 32'hDEAD_BEEF, 32'h0000_0123, 1'b1, -1);

    // Asynchronous reset mid-multiply, asserted between clock edges.
    @(negedge clk);
    ctrl = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    op("m_3x4", 2'b01, 32'd3, 32'd4, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 1) ry = ry >> $urandom_range(0, 31);
      op($sformatf("rnd%0d", i), 2'($urandom_range(1, 2)), rx, ry,
         1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
